// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register bank fed by a one-hot 8-way load demux.
//   Writes go to word[address] when load is high; reads are combinational.
//   A clear request starts a sweep that zeroes one word per cycle (8 cycles).
//   Tracks which words were written since their last reset/clear, and pulses
//   drop for one cycle after any load that the bank had to ignore.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   in       write data (WIDTH bits)
//   load     write request for word[address]
//   address  word select for write and read
//   clear    request a sequential clear sweep
//   out      word[address], combinational
//   busy     high while the clear sweep runs
//   written  per-word written mask
//   drop     one-cycle pulse after an ignored load
module ram8_bank #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [7:0]       written,
  output logic             drop
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       written_q, written_d;
  logic             drop_q, drop_d;
  logic [7:0]       load_en;

  // One-hot word enables, same mapping as the upstream 8-way demux.
  assign load_en = {7'b0, load} << address;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    written_d = written_q;
    drop_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          // Clear wins over a simultaneous load.
          state_d = StClear;
          ptr_d   = 3'd0;
          drop_d  = load;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (load_en[i]) begin
              mem_d[i]     = in;
              written_d[i] = 1'b1;
            end
          end
        end
      end
      StClear: begin
        mem_d[ptr_q]     = '0;
        written_d[ptr_q] = 1'b0;
        drop_d           = load;
        if (ptr_q == 3'd7) begin
          state_d = StIdle;
          ptr_d   = 3'd0;
        end else begin
          ptr_d = ptr_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      written_q <= 8'h00;
      drop_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      written_q <= written_d;
      drop_q    <= drop_d;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out     = mem_q[address];
  assign busy    = (state_q == StClear);
  assign written = written_q;
  assign drop    = drop_q;

endmodule
